// File: rtl/cve2_pmp_lsu_gate.sv
// rtl/cve2_pmp_lsu_gate.sv - LSU gate that PMP-checks both halves of a split access before any bus request
// Optional PMP-deny counter enabled by defining CVE2_PMP_GATE_DENY_CNT_EN.

package vcve2_pkg;
   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_H = 2'b10,
      PRIV_LVL_M = 2'b11
   } priv_lvl_e;

   typedef enum logic [1:0] {
      PMP_ACC_EXEC  = 2'b00,
      PMP_ACC_WRITE = 2'b01,
      PMP_ACC_READ  = 2'b10
   } pmp_req_e;
endpackage

module cve2_pmp_lsu_gate #(
   parameter int unsigned DenyCntWidth = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,

   input  logic                      lsu_req_i,
   output logic                      lsu_gnt_o,
   input  logic [31:0]               lsu_addr_i,
   input  logic                      lsu_we_i,
   input  logic [1:0]                lsu_size_i,
   input  vcve2_pkg::priv_lvl_e      priv_mode_i,

   output logic                      lsu_rvalid_o,
   output logic                      lsu_err_o,
   output logic                      lsu_pmp_err_o,

   output logic [33:0]               pmp_req_addr_o,
   output vcve2_pkg::pmp_req_e       pmp_req_type_o,
   output vcve2_pkg::priv_lvl_e      pmp_priv_mode_o,
   input  logic                      pmp_req_err_i,

   output logic                      data_req_o,
   input  logic                      data_gnt_i,
   output logic [31:0]               data_addr_o,
   output logic                      data_we_o,
   output logic [3:0]                data_be_o,
   input  logic                      data_rvalid_i,
   input  logic                      data_err_i,

   output logic [DenyCntWidth-1:0]   deny_cnt_o
);

   typedef enum logic [3:0] {
      IDLE, CHK1, CHK2, ISS1, WAIT1, ISS2, WAIT2, PERR, RESP
   } state_e;

   state_e                  state_q, state_d;
   logic [31:0]             addr_q;
   logic                    we_q;
   logic [1:0]              size_q;
   vcve2_pkg::priv_lvl_e    priv_q;
   logic                    err_q;

   logic [3:0]              be_base;
   logic [7:0]              be_full;
   logic                    split;
   logic [29:0]             word_a;
   logic [29:0]             word_b;
   logic [31:0]             part1_addr;
   logic [31:0]             part2_addr;

   // Size 3 falls into the default arm and is handled as a word.
   always_comb begin
      be_base = 4'hF;
      case (size_q)
         2'd0:    be_base = 4'h1;
         2'd1:    be_base = 4'h3;
         default: be_base = 4'hF;
      endcase
   end

   assign be_full    = {4'b0000, be_base} << addr_q[1:0];
   assign split      = |be_full[7:4];
   assign word_a     = addr_q[31:2];
   assign word_b     = word_a + 30'd1;
   assign part1_addr = {word_a, 2'b00};
   assign part2_addr = {word_b, 2'b00};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (lsu_req_i)     state_d = CHK1;
         CHK1: begin
            if (pmp_req_err_i)     state_d = PERR;
            else if (split)        state_d = CHK2;
            else                   state_d = ISS1;
         end
         CHK2:  state_d = pmp_req_err_i ? PERR : ISS1;
         ISS1:  if (data_gnt_i)    state_d = WAIT1;
         WAIT1: if (data_rvalid_i) state_d = split ? ISS2 : RESP;
         ISS2:  if (data_gnt_i)    state_d = WAIT2;
         WAIT2: if (data_rvalid_i) state_d = RESP;
         PERR:  state_d = IDLE;
         RESP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      lsu_gnt_o       = 1'b0;
      lsu_rvalid_o    = 1'b0;
      lsu_err_o       = 1'b0;
      lsu_pmp_err_o   = 1'b0;
      pmp_req_addr_o  = 34'd0;
      pmp_req_type_o  = vcve2_pkg::PMP_ACC_READ;
      pmp_priv_mode_o = vcve2_pkg::PRIV_LVL_U;
      data_req_o      = 1'b0;
      data_addr_o     = 32'd0;
      data_we_o       = 1'b0;
      data_be_o       = 4'h0;
      case (state_q)
         IDLE: lsu_gnt_o = 1'b1;
         CHK1, CHK2: begin
            pmp_req_addr_o  = {2'b00, (state_q == CHK1) ? part1_addr : part2_addr};
            pmp_req_type_o  = we_q ? vcve2_pkg::PMP_ACC_WRITE : vcve2_pkg::PMP_ACC_READ;
            pmp_priv_mode_o = priv_q;
         end
         ISS1: begin
            data_req_o  = 1'b1;
            data_addr_o = part1_addr;
            data_we_o   = we_q;
            data_be_o   = be_full[3:0];
         end
         ISS2: begin
            data_req_o  = 1'b1;
            data_addr_o = part2_addr;
            data_we_o   = we_q;
            data_be_o   = be_full[7:4];
         end
         PERR: begin
            lsu_rvalid_o  = 1'b1;
            lsu_pmp_err_o = 1'b1;
         end
         RESP: begin
            lsu_rvalid_o = 1'b1;
            lsu_err_o    = err_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q <= 32'd0;
         we_q   <= 1'b0;
         size_q <= 2'd0;
         priv_q <= vcve2_pkg::PRIV_LVL_U;
      end else if (state_q == IDLE && lsu_req_i) begin
         addr_q <= lsu_addr_i;
         we_q   <= lsu_we_i;
         size_q <= lsu_size_i;
         priv_q <= priv_mode_i;
      end
   end

   // Bus errors from either half accumulate until the single response goes out.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (state_q == RESP || state_q == PERR) begin
         err_q <= 1'b0;
      end else if ((state_q == WAIT1 || state_q == WAIT2) && data_rvalid_i) begin
         err_q <= err_q | data_err_i;
      end
   end

`ifdef CVE2_PMP_GATE_DENY_CNT_EN
   logic [DenyCntWidth-1:0] deny_cnt_q;
   logic                    perr_entry;

   assign perr_entry = (state_d == PERR) && (state_q != PERR);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         deny_cnt_q <= '0;
      end else if (perr_entry && !(&deny_cnt_q)) begin
         deny_cnt_q <= deny_cnt_q + {{(DenyCntWidth-1){1'b0}}, 1'b1};
      end
   end

   assign deny_cnt_o = deny_cnt_q;
`else
   assign deny_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cve2_pmp_lsu_gate.sv
// tb/tb_cve2_pmp_lsu_gate.sv - table-driven self-checking bench for cve2_pmp_lsu_gate
// Expected deny count follows CVE2_PMP_GATE_DENY_CNT_EN.

module tb_cve2_pmp_lsu_gate;

   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b0;
   logic                 lsu_req_i = 1'b0;
   logic                 lsu_gnt_o;
   logic [31:0]          lsu_addr_i = 32'd0;
   logic                 lsu_we_i = 1'b0;
   logic [1:0]           lsu_size_i = 2'd0;
   vcve2_pkg::priv_lvl_e priv_mode_i = vcve2_pkg::PRIV_LVL_U;
   logic                 lsu_rvalid_o;
   logic                 lsu_err_o;
   logic                 lsu_pmp_err_o;
   logic [33:0]          pmp_req_addr_o;
   vcve2_pkg::pmp_req_e  pmp_req_type_o;
   vcve2_pkg::priv_lvl_e pmp_priv_mode_o;
   logic                 pmp_req_err_i;
   logic                 data_req_o;
   logic                 data_gnt_i = 1'b0;
   logic [31:0]          data_addr_o;
   logic                 data_we_o;
   logic [3:0]           data_be_o;
   logic                 data_rvalid_i = 1'b0;
   logic                 data_err_i = 1'b0;
   logic [15:0]          deny_cnt_o;

   cve2_pmp_lsu_gate #(.DenyCntWidth(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .lsu_req_i(lsu_req_i), .lsu_gnt_o(lsu_gnt_o), .lsu_addr_i(lsu_addr_i),
      .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i), .priv_mode_i(priv_mode_i),
      .lsu_rvalid_o(lsu_rvalid_o), .lsu_err_o(lsu_err_o), .lsu_pmp_err_o(lsu_pmp_err_o),
      .pmp_req_addr_o(pmp_req_addr_o), .pmp_req_type_o(pmp_req_type_o),
      .pmp_priv_mode_o(pmp_priv_mode_o), .pmp_req_err_i(pmp_req_err_i),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
      .data_we_o(data_we_o), .data_be_o(data_be_o), .data_rvalid_i(data_rvalid_i),
      .data_err_i(data_err_i), .deny_cnt_o(deny_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // PMP model: denies exactly one configured word address.
   logic        deny_en = 1'b0;
   logic [31:0] deny_addr = 32'd0;
   assign pmp_req_err_i = deny_en && (pmp_req_addr_o == {2'b00, deny_addr});

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        we;
      logic [1:0]  priv;
      logic        deny_en;
      logic [31:0] deny_addr;
      logic        berr1;
      logic        berr2;
      int          exp_nreq;
      logic [31:0] exp_a1;
      logic [3:0]  exp_be1;
      logic [31:0] exp_a2;
      logic [3:0]  exp_be2;
      logic        exp_perr;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs [12];
   int   checks = 0;
   int   failures = 0;
   int   exp_deny = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input int idx, input vec_t v);
      int          n_req = 0;
      int          req_age = 0;
      bit          rv_pend = 0;
      int          rv_cnt = 0;
      int          done_cyc = -1;
      logic        got_perr = 0;
      logic        got_err = 0;
      logic [31:0] log_a [2];
      logic [3:0]  log_be [2];
      logic        log_we [2];
      string       p;
      p = $sformatf("v%0d", idx);
      log_a[0] = 0; log_a[1] = 0; log_be[0] = 0; log_be[1] = 0; log_we[0] = 0; log_we[1] = 0;
      deny_en = v.deny_en;
      deny_addr = v.deny_addr;
      @(negedge clk_i);
      check({p, "_gnt_idle"}, lsu_gnt_o, 1'b1);
      lsu_req_i = 1'b1;
      lsu_addr_i = v.addr;
      lsu_size_i = v.size;
      lsu_we_i = v.we;
      priv_mode_i = vcve2_pkg::priv_lvl_e'(v.priv);
      @(posedge clk_i);
      #1 lsu_req_i = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk_i);
         if (cyc == 0) begin
            check({p, "_pmp_type"}, pmp_req_type_o,
                  v.we ? vcve2_pkg::PMP_ACC_WRITE : vcve2_pkg::PMP_ACC_READ);
            check({p, "_pmp_priv"}, pmp_priv_mode_o, v.priv);
         end
         if (done_cyc >= 0) begin
            check({p, "_rvalid_drop"}, lsu_rvalid_o, 1'b0);
            check({p, "_back_idle"}, lsu_gnt_o, 1'b1);
            break;
         end
         data_gnt_i = 1'b0;
         data_rvalid_i = 1'b0;
         data_err_i = 1'b0;
         if (lsu_rvalid_o) begin
            rv_cnt++;
            done_cyc = cyc;
            got_perr = lsu_pmp_err_o;
            got_err = lsu_err_o;
            if (v.exp_lat != 0) check({p, "_latency"}, cyc + 1, v.exp_lat);
         end
         if (rv_pend) begin
            data_rvalid_i = 1'b1;
            data_err_i = (n_req == 1) ? v.berr1 : v.berr2;
            rv_pend = 0;
         end else if (data_req_o) begin
            if (req_age == 0 && n_req < 2) begin
               log_a[n_req] = data_addr_o;
               log_be[n_req] = data_be_o;
               log_we[n_req] = data_we_o;
            end else if (n_req < 2) begin
               check({p, "_addr_hold"}, data_addr_o, log_a[n_req]);
            end
            if (req_age == 1) begin
               data_gnt_i = 1'b1;
               rv_pend = 1;
               n_req++;
               req_age = 0;
            end else begin
               req_age++;
            end
         end
      end
      data_gnt_i = 1'b0;
      data_rvalid_i = 1'b0;
      data_err_i = 1'b0;
      if (done_cyc < 0) check({p, "_timeout"}, 1'b1, 1'b0);
`ifdef CVE2_PMP_GATE_DENY_CNT_EN
      if (v.exp_perr) exp_deny++;
`endif
      check({p, "_rv_count"}, rv_cnt, 1);
      check({p, "_nreq"}, n_req, v.exp_nreq);
      check({p, "_pmp_err"}, got_perr, v.exp_perr);
      check({p, "_bus_err"}, got_err, v.exp_err);
      check({p, "_deny_cnt"}, deny_cnt_o, exp_deny);
      if (v.exp_nreq >= 1) begin
         check({p, "_a1"}, log_a[0], v.exp_a1);
         check({p, "_be1"}, log_be[0], v.exp_be1);
         check({p, "_we1"}, log_we[0], v.we);
      end
      if (v.exp_nreq == 2) begin
         check({p, "_a2"}, log_a[1], v.exp_a2);
         check({p, "_be2"}, log_be[1], v.exp_be2);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int  guard;
      bit  saw_rv;
      //        addr          sz we pr den deny_addr    b1 b2 n  a1            be1   a2            be2   pe er lat
      vecs[0]  = '{32'h00001000, 2, 0, 3, 0, 32'h0,        0, 0, 1, 32'h00001000, 4'hF, 32'h0,        4'h0, 0, 0, 0};
      vecs[1]  = '{32'h00001003, 2, 1, 0, 0, 32'h0,        0, 0, 2, 32'h00001000, 4'h8, 32'h00001004, 4'h7, 0, 0, 0};
      vecs[2]  = '{32'h00002003, 1, 0, 3, 1, 32'h00002004, 0, 0, 0, 32'h0,        4'h0, 32'h0,        4'h0, 1, 0, 3};
      vecs[3]  = '{32'hFFFFFFFE, 2, 0, 3, 0, 32'h0,        0, 0, 2, 32'hFFFFFFFC, 4'hC, 32'h00000000, 4'h3, 0, 0, 0};
      vecs[4]  = '{32'h00001002, 2, 0, 3, 0, 32'h0,        1, 0, 2, 32'h00001000, 4'hC, 32'h00001004, 4'h3, 0, 1, 0};
      vecs[5]  = '{32'h00003001, 0, 0, 1, 1, 32'h00003000, 0, 0, 0, 32'h0,        4'h0, 32'h0,        4'h0, 1, 0, 2};
      vecs[6]  = '{32'h00004000, 3, 1, 3, 0, 32'h0,        0, 0, 1, 32'h00004000, 4'hF, 32'h0,        4'h0, 0, 0, 0};
      vecs[7]  = '{32'h00005001, 1, 1, 0, 0, 32'h0,        0, 0, 1, 32'h00005000, 4'h6, 32'h0,        4'h0, 0, 0, 0};
      vecs[8]  = '{32'h00005003, 0, 1, 3, 0, 32'h0,        0, 0, 1, 32'h00005000, 4'h8, 32'h0,        4'h0, 0, 0, 0};
      vecs[9]  = '{32'h00005002, 1, 0, 3, 0, 32'h0,        1, 0, 1, 32'h00005000, 4'hC, 32'h0,        4'h0, 0, 1, 0};
      vecs[10] = '{32'h00006003, 1, 0, 3, 1, 32'h00006000, 0, 0, 0, 32'h0,        4'h0, 32'h0,        4'h0, 1, 0, 2};
      vecs[11] = '{32'h00001001, 2, 0, 3, 0, 32'h0,        0, 1, 2, 32'h00001000, 4'hE, 32'h00001004, 4'h1, 0, 1, 0};

      repeat (3) @(negedge clk_i);
      check("rst_gnt", lsu_gnt_o, 1'b1);
      check("rst_rvalid", lsu_rvalid_o, 1'b0);
      check("rst_data_req", data_req_o, 1'b0);
      check("rst_pmp_addr", pmp_req_addr_o, 34'd0);
      check("rst_pmp_type", pmp_req_type_o, vcve2_pkg::PMP_ACC_READ);
      check("rst_deny_cnt", deny_cnt_o, 16'd0);
      rst_ni = 1'b1;

      for (int i = 0; i < 12; i++) run_txn(i, vecs[i]);

      // gnt and rvalid together count only as gnt; the real response comes later.
      deny_en = 1'b0;
      @(negedge clk_i);
      lsu_req_i = 1'b1; lsu_addr_i = 32'h00008000; lsu_size_i = 2'd2; lsu_we_i = 1'b0;
      @(posedge clk_i);
      #1 lsu_req_i = 1'b0;
      guard = 0;
      do begin @(negedge clk_i); guard++; end while (!data_req_o && guard < 10);
      check("same_cyc_req_seen", data_req_o, 1'b1);
      data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_err_i = 1'b1;
      @(negedge clk_i);
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
      check("same_cyc_no_early_rv", lsu_rvalid_o, 1'b0);
      @(negedge clk_i);
      check("same_cyc_still_waiting", lsu_rvalid_o, 1'b0);
      check("same_cyc_no_rereq", data_req_o, 1'b0);
      data_rvalid_i = 1'b1;
      @(negedge clk_i);
      data_rvalid_i = 1'b0;
      check("same_cyc_rv", lsu_rvalid_o, 1'b1);
      check("same_cyc_err", lsu_err_o, 1'b0);
      @(negedge clk_i);

      // Reset while waiting on part1 of a split read.
      lsu_req_i = 1'b1; lsu_addr_i = 32'h00007002; lsu_size_i = 2'd2; lsu_we_i = 1'b0;
      @(posedge clk_i);
      #1 lsu_req_i = 1'b0;
      guard = 0;
      do begin @(negedge clk_i); guard++; end while (!data_req_o && guard < 10);
      check("rst_mid_req_seen", data_req_o, 1'b1);
      data_gnt_i = 1'b1;
      @(negedge clk_i);
      data_gnt_i = 1'b0;
      check("rst_mid_in_wait", lsu_gnt_o, 1'b0);
      rst_ni = 1'b0;
      #1;
      check("rst_mid_gnt", lsu_gnt_o, 1'b1);
      check("rst_mid_data_req", data_req_o, 1'b0);
      check("rst_mid_rvalid", lsu_rvalid_o, 1'b0);
      exp_deny = 0;
      check("rst_mid_deny_cnt", deny_cnt_o, exp_deny);
      data_rvalid_i = 1'b1;
      @(negedge clk_i);
      rst_ni = 1'b1;
      saw_rv = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         if (k == 1) data_rvalid_i = 1'b0;
         if (lsu_rvalid_o || !lsu_gnt_o) saw_rv = 1;
      end
      check("late_rvalid_ignored", saw_rv, 1'b0);

      run_txn(12, vecs[0]);
      run_txn(13, vecs[2]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
